// File: rtl/ipgu_pyramid_scan.sv
// Image pyramid scanner: walks sliding windows over NUM_LEVELS scale levels,
// resamples each window nearest-neighbour from a sync-read pixel RAM and hands it off.
//
// state   | meaning
// IDLE    | waiting for start
// SETUP   | fit-test origin, advance row/level on misfit, preload accumulators
// FETCH   | one RAM read per cycle, WIN*WIN reads, row-major
// DRAIN   | capture the last read datum
// PRESENT | window valid, waiting for win_rdy
// NEXT    | step origin by STRIDE
// DONE    | one-cycle done pulse
module ipgu_pyramid_scan #(
  parameter int PIX_W      = 8,
  parameter int IMG_W      = 300,
  parameter int IMG_H      = 300,
  parameter int WIN        = 20,
  parameter int STRIDE     = 4,
  parameter int NUM_LEVELS = 4,
  parameter int FRAC       = 8,
  parameter int ADDR_W     = $clog2(IMG_W*IMG_H),
  parameter int LVL_W      = $clog2(NUM_LEVELS)+1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [FRAC+3:0]          step_inc,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_rd_en,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [PIX_W-1:0]         ram_rd_data,
  output logic                     win_vld,
  input  logic                     win_rdy,
  output logic [WIN*WIN*PIX_W-1:0] win_data,
  output logic [8:0]               win_x,
  output logic [8:0]               win_y,
  output logic [LVL_W-1:0]         win_level
);

  localparam int N      = WIN*WIN;
  localparam int S_W    = FRAC+8;
  localparam int ACC_W  = S_W+10;
  localparam int SLOT_W = $clog2(N);
  localparam int COL_W  = $clog2(WIN)+1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_DRAIN, S_PRESENT, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [S_W-1:0]          step;
  logic [FRAC+3:0]         inc_q;
  logic [8:0]              ox, oy;
  logic [LVL_W-1:0]        level;
  logic [ACC_W-1:0]        col_base, col_acc, row_acc;
  logic [SLOT_W-1:0]       pix_left, rd_slot, wr_slot;
  logic [COL_W-1:0]        col_left;
  logic                    wr_en;
  logic [N-1:0][PIX_W-1:0] win_buf;

  logic [ACC_W-1:0] step_w, ox_prod, oy_prod, x_end, y_end, sx, sy;
  logic fit_x, fit_y, win_ok, skip_all, lvl_adv, row_adv, last_lvl;

  assign step_w  = ACC_W'(step);
  assign ox_prod = ACC_W'(ox) * step_w;
  assign oy_prod = ACC_W'(oy) * step_w;
  assign x_end   = ((ACC_W'(ox) + ACC_W'(WIN-1)) * step_w) >> FRAC;
  assign y_end   = ((ACC_W'(oy) + ACC_W'(WIN-1)) * step_w) >> FRAC;
  assign fit_x   = x_end <= ACC_W'(IMG_W-1);
  assign fit_y   = y_end <= ACC_W'(IMG_H-1);
  assign win_ok  = fit_x && fit_y;
  // A level whose (0,0) window does not fit means every later (larger-step) level fails too.
  assign skip_all = (!fit_x && ox == 9'd0) || (!fit_y && oy == 9'd0);
  assign lvl_adv  = !skip_all && !fit_y;
  assign row_adv  = !skip_all && fit_y && !fit_x;
  assign last_lvl = level == LVL_W'(NUM_LEVELS-1);

  assign sx = col_acc >> FRAC;
  assign sy = row_acc >> FRAC;
  assign ram_addr = ram_rd_en ? ADDR_W'(sy * ACC_W'(IMG_W) + sx) : '0;

  assign win_data  = win_buf;
  assign win_x     = ox;
  assign win_y     = oy;
  assign win_level = level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    win_vld   = 1'b0;
    ram_rd_en = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SETUP;
      S_SETUP: begin
        busy = 1'b1;
        if (skip_all || (lvl_adv && last_lvl)) state_nxt = S_DONE;
        else if (win_ok)                       state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        ram_rd_en = 1'b1;
        if (pix_left == '0) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        busy    = 1'b1;
        win_vld = 1'b1;
        if (win_rdy) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        busy      = 1'b1;
        state_nxt = S_SETUP;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step     <= '0;
      inc_q    <= '0;
      ox       <= '0;
      oy       <= '0;
      level    <= '0;
      col_base <= '0;
      col_acc  <= '0;
      row_acc  <= '0;
      pix_left <= '0;
      col_left <= '0;
      rd_slot  <= '0;
      wr_slot  <= '0;
      wr_en    <= 1'b0;
      win_buf  <= '0;
    end else begin
      // RAM data returns one cycle after the read, so the slot is delayed to match.
      wr_en   <= ram_rd_en;
      wr_slot <= rd_slot;
      if (wr_en) win_buf[wr_slot] <= ram_rd_data;
      case (state)
        S_IDLE: if (start) begin
          step  <= S_W'(1 << FRAC);
          inc_q <= step_inc;
          ox    <= '0;
          oy    <= '0;
          level <= '0;
        end
        S_SETUP: begin
          if (lvl_adv && !last_lvl) begin
            level <= level + LVL_W'(1);
            step  <= step + S_W'(inc_q);
            ox    <= '0;
            oy    <= '0;
          end else if (row_adv) begin
            ox <= '0;
            oy <= oy + 9'(STRIDE);
          end else if (win_ok) begin
            col_base <= ox_prod;
            col_acc  <= ox_prod;
            row_acc  <= oy_prod;
            pix_left <= SLOT_W'(N-1);
            col_left <= COL_W'(WIN-1);
            rd_slot  <= '0;
          end
        end
        S_FETCH: begin
          pix_left <= pix_left - SLOT_W'(1);
          rd_slot  <= rd_slot + SLOT_W'(1);
          if (col_left == '0) begin
            col_left <= COL_W'(WIN-1);
            col_acc  <= col_base;
            row_acc  <= row_acc + step_w;
          end else begin
            col_left <= col_left - COL_W'(1);
            col_acc  <= col_acc + step_w;
          end
        end
        S_NEXT: ox <= ox + 9'(STRIDE);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipgu_pyramid_scan.sv
// Directed bench for ipgu_pyramid_scan: 8x8 image with WIN 4 (dut a) and an
// oversized WIN 10 (dut b); RAM content equals its address.
module tb_ipgu_pyramid_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         start_a, busy_a, done_a, ram_rd_en_a, win_vld_a, win_rdy_a;
  logic [11:0]  step_inc_a;
  logic [5:0]   ram_addr_a;
  logic [7:0]   ram_rd_data_a = 8'd0;
  logic [127:0] win_data_a;
  logic [8:0]   win_x_a, win_y_a;
  logic [1:0]   win_level_a;

  logic         start_b, busy_b, done_b, ram_rd_en_b, win_vld_b, win_rdy_b;
  logic [11:0]  step_inc_b;
  logic [5:0]   ram_addr_b;
  logic [7:0]   ram_rd_data_b = 8'd0;
  logic [799:0] win_data_b;
  logic [8:0]   win_x_b, win_y_b;
  logic [1:0]   win_level_b;

  ipgu_pyramid_scan #(.PIX_W(8), .IMG_W(8), .IMG_H(8), .WIN(4), .STRIDE(4),
                      .NUM_LEVELS(2), .FRAC(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .step_inc(step_inc_a),
    .busy(busy_a), .done(done_a), .ram_rd_en(ram_rd_en_a), .ram_addr(ram_addr_a),
    .ram_rd_data(ram_rd_data_a), .win_vld(win_vld_a), .win_rdy(win_rdy_a),
    .win_data(win_data_a), .win_x(win_x_a), .win_y(win_y_a), .win_level(win_level_a)
  );

  ipgu_pyramid_scan #(.PIX_W(8), .IMG_W(8), .IMG_H(8), .WIN(10), .STRIDE(4),
                      .NUM_LEVELS(2), .FRAC(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .step_inc(step_inc_b),
    .busy(busy_b), .done(done_b), .ram_rd_en(ram_rd_en_b), .ram_addr(ram_addr_b),
    .ram_rd_data(ram_rd_data_b), .win_vld(win_vld_b), .win_rdy(win_rdy_b),
    .win_data(win_data_b), .win_x(win_x_b), .win_y(win_y_b), .win_level(win_level_b)
  );

  int reads_b = 0;
  int vlds_b  = 0;
  always @(posedge clk) begin
    if (ram_rd_en_a) ram_rd_data_a <= 8'(ram_addr_a);
    if (ram_rd_en_b) begin
      ram_rd_data_b <= 8'(ram_addr_b);
      reads_b       <= reads_b + 1;
    end
    if (win_vld_b) vlds_b <= vlds_b + 1;
  end

  typedef struct {
    int          x;
    int          y;
    int          lvl;
    logic [15:0] rows;  // nibble r = source row of window row r
    logic [15:0] cols;  // nibble c = source column of window column c
  } vec_t;

  vec_t vecs[5];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_win(input logic [15:0] rows, input logic [15:0] cols);
    logic [127:0] d;
    d = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        d[(r*4+c)*8 +: 8] = 8'(int'(rows[r*4 +: 4]) * 8 + int'(cols[c*4 +: 4]));
    return d;
  endfunction

  task automatic wait_vld_a(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 200 && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (win_vld_a) ok = 1'b1;
      else if (done_a) cyc = 200;
    end
  endtask

  task automatic run_scan(input logic [11:0] inc, input int nwin, input bit rep,
                          input bit hold, input bit restart);
    int cyc;
    bit ok;
    int idx;
    int exp_lvl;
    bit seen_done;
    bit stray;
    step_inc_a = inc;
    start_a    = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("busy_after_start", busy_a, 1);
    for (int w = 0; w < nwin; w++) begin
      wait_vld_a(cyc, ok);
      chk("vld_timeout", ok, 1);
      if (w == 0) chk("first_latency", 1 + cyc, 19);
      if (w == 1) chk("win_spacing", cyc, 19);
      idx     = rep ? (w % 4) : w;
      exp_lvl = rep ? (w / 4) : vecs[idx].lvl;
      chk("win_x", win_x_a, vecs[idx].x);
      chk("win_y", win_y_a, vecs[idx].y);
      chk("win_level", win_level_a, exp_lvl);
      chk("win_data", win_data_a, exp_win(vecs[idx].rows, vecs[idx].cols));
      if (hold && w == 0) begin
        for (int k = 0; k < 50; k++) begin
          @(posedge clk); #1;
          chk("hold_vld", win_vld_a, 1);
          chk("hold_data", win_data_a, exp_win(vecs[idx].rows, vecs[idx].cols));
          chk("hold_rd_en", ram_rd_en_a, 0);
        end
      end
      if (restart && w == 0) begin
        step_inc_a = 12'h080;
        start_a    = 1'b1;
        @(posedge clk); #1;
        start_a    = 1'b0;
        step_inc_a = inc;
        chk("restart_ignored", {win_vld_a, win_x_a, win_y_a}, {1'b1, 9'd0, 9'd0});
      end
      win_rdy_a = 1'b1;
      @(posedge clk); #1;
      win_rdy_a = 1'b0;
      chk("vld_fall", win_vld_a, 0);
    end
    seen_done = 1'b0;
    stray     = 1'b0;
    for (int k = 0; k < 40 && !seen_done && !stray; k++) begin
      @(posedge clk); #1;
      if (done_a) seen_done = 1'b1;
      else if (win_vld_a) stray = 1'b1;
    end
    chk("done_seen", {seen_done, stray}, 2'b10);
    chk("done_busy", busy_a, 0);
    @(posedge clk); #1;
    chk("done_pulse_len", {done_a, busy_a}, 2'b00);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{x: 0, y: 0, lvl: 0, rows: 16'h3210, cols: 16'h3210};
    vecs[1] = '{x: 4, y: 0, lvl: 0, rows: 16'h3210, cols: 16'h7654};
    vecs[2] = '{x: 0, y: 4, lvl: 0, rows: 16'h7654, cols: 16'h3210};
    vecs[3] = '{x: 4, y: 4, lvl: 0, rows: 16'h7654, cols: 16'h7654};
    vecs[4] = '{x: 0, y: 0, lvl: 1, rows: 16'h4310, cols: 16'h4310};

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    win_rdy_a = 1'b0; win_rdy_b = 1'b0;
    step_inc_a = '0; step_inc_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ctrl_a", {busy_a, done_a, win_vld_a, ram_rd_en_a, ram_addr_a}, 0);
    chk("rst_data_a", win_data_a, 0);
    chk("rst_pos_a", {win_x_a, win_y_a, win_level_a}, 0);
    chk("rst_ctrl_b", {busy_b, done_b, win_vld_b, ram_rd_en_b}, 0);

    // oversized window: nothing fits anywhere
    step_inc_b = 12'h080;
    start_b    = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cnt = 1;
    while (!done_b && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("t4_done_latency", cnt, 2);
    chk("t4_reads", reads_b, 0);
    chk("t4_vld", vlds_b, 0);
    @(posedge clk); #1;
    chk("t4_idle", {done_b, busy_b}, 2'b00);

    run_scan(12'h080, 5, 1'b0, 1'b1, 1'b0);
    run_scan(12'h000, 8, 1'b1, 1'b0, 1'b1);

    // reset in the middle of a fetch
    step_inc_a = 12'h080;
    start_a    = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("t5_in_fetch", ram_rd_en_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_ctrl", {busy_a, done_a, win_vld_a, ram_rd_en_a, ram_addr_a}, 0);
    chk("t5_rst_pos", {win_x_a, win_y_a, win_level_a}, 0);
    chk("t5_rst_data", win_data_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_scan(12'h080, 5, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
